ssr_photon_decider: RTL and testbench
=====================================

Name: ssr_photon_decider

Overview:
- Single-shot-readout (SSR) decision stage that sits directly upstream of the jump-address bitstream serializer.
- Counts detector photon edges into two bins (left/right) selected by the laser swap signal while the ssr gate is open, across one or more repetitions.
- On readout, or when a repetition target is reached, compares the bins against programmable thresholds.
- Produces the registered `flip` level that enables the serializer, plus a one-cycle `decision_valid` strobe.

Parameters:
- CNT_W, 16, width of each photon bin counter and of the thresholds.
- REP_W, 16, width of the repetition counter and repetition target.
- SYNC_STAGES, 2, number of flops in each input synchronizer (minimum 2).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- photons  in  1  asynchronous detector pulse; each rising edge is one photon.
- swap  in  1  asynchronous laser/swap level; 0 counts into the left bin, 1 into the right bin.
- ssr  in  1  asynchronous SSR gate; counting is enabled while high, and each falling edge ends one repetition.
- readout  in  1  asynchronous; its rising edge forces a decision.
- threshold  in  CNT_W  required margin of count_right over count_left.
- min_total  in  CNT_W  minimum count_left+count_right for a valid flip.
- rep_target  in  REP_W  repetitions before an automatic decision; 0 disables the automatic decision.
- flip  out  1  registered decision, held until the next decision.
- decision_valid  out  1  one-cycle pulse marking that flip was just updated.
- count_left  out  CNT_W  left bin value.
- count_right  out  CNT_W  right bin value.
- rep_count  out  REP_W  completed repetitions.
- busy  out  1  high while in ACCUM or DECIDE.
- overflow  out  1  sticky saturation flag; cleared only by reset or CLEAR.

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronizer flops 0.
- Reset asserted mid-operation aborts any accumulation or decision, with no decision_valid pulse.
- Input conditioning:
  - photons, swap, ssr and readout each pass through SYNC_STAGES flops.
  - A rising or falling edge is detected by comparing the synchronized value with a one-cycle-delayed copy.
- IDLE:
  - Counters are 0.
  - A synchronized ssr rising edge moves to ACCUM.
  - A readout rising edge in IDLE moves to DECIDE, evaluating on zero counts.
- ACCUM:
  - Each photon rising edge with ssr_s=1 increments the bin selected by swap_s in the same cycle.
  - Bins saturate at 2^CNT_W-1; an increment attempted at saturation sets overflow.
  - Each ssr_s falling edge increments rep_count, saturating at 2^REP_W-1.
  - Move to DECIDE on a readout rising edge, or on the cycle rep_count is incremented to equal a nonzero rep_target.
  - A photon edge coinciding with the DECIDE trigger is counted before evaluation.
- DECIDE (1 cycle):
  - Evaluate using CNT_W+1-bit arithmetic, no wrap: flip <= (count_right >= count_left + threshold) && (count_left + count_right >= min_total).
  - decision_valid <= 1 for exactly this one registered cycle.
  - Next state CLEAR.
  - With zero counts, threshold=0 and min_total=0, the result is flip=1.
- CLEAR (1 cycle):
  - Bins, rep_count and overflow are set to 0.
  - flip is held.
  - Next state IDLE, or ACCUM if ssr_s=1.
- Photon edges arriving in DECIDE or CLEAR are dropped.
- Latency: decision_valid goes high SYNC_STAGES+2 rising edges after the first edge that samples readout=1 at the pin.
  - With SYNC_STAGES=2 this is edge 4.
  - flip updates on the same edge as decision_valid.
- A readout rising edge during DECIDE or CLEAR is ignored; the level must be low for at least 1 synchronized cycle before it can re-trigger.
- swap changes take effect SYNC_STAGES cycles after the pin and are aligned with the photon synchronizer, so photon and swap stay coherent.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then 10 idle cycles -> flip=0, decision_valid=0, counts=0, busy=0.
- ssr high; 3 photons with swap=0 and 12 photons with swap=1 (photon edges ≥4 cycles apart); ssr low; readout pulse; threshold=5, min_total=10 -> count_left=3, count_right=12, flip=1, decision_valid is a single pulse on edge 4 after readout; counts=0 two cycles later.
- Same run with threshold=10 -> flip=0; change to 5 right and 4 left with min_total=10 -> flip=0 (total 9).
- rep_target=3, three ssr windows of 2 right photons each, no readout -> auto decision on the 3rd ssr fall, rep_count=3 at decide, flip=1 when threshold=6 and min_total=0.
- CNT_W=4: 17 right photons -> count_right saturates at 15, overflow=1, decision uses 15; overflow=0 after CLEAR.
- Assert reset during ACCUM with count_right=7 -> next cycle counts=0, state IDLE, flip=0, no decision_valid; also readout and photon edges in the same synchronized cycle -> that photon is included in the evaluated count.

Source files
------------

// File: rtl/ssr_photon_decider.sv
// Single-shot-readout decision stage: bins synchronized photon edges by swap level
// across SSR repetitions, then registers a thresholded flip decision for the serializer.
module ssr_photon_decider #(
  parameter int CNT_W       = 16,
  parameter int REP_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             photons,
  input  logic             swap,
  input  logic             ssr,
  input  logic             readout,
  input  logic [CNT_W-1:0] threshold,
  input  logic [CNT_W-1:0] min_total,
  input  logic [REP_W-1:0] rep_target,
  output logic             flip,
  output logic             decision_valid,
  output logic [CNT_W-1:0] count_left,
  output logic [CNT_W-1:0] count_right,
  output logic [REP_W-1:0] rep_count,
  output logic             busy,
  output logic             overflow
);

  localparam int NUM_IN = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [REP_W-1:0] REP_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, CLEAR} state_t;

  logic [NUM_IN-1:0] pin_vec;
  logic [NUM_IN-1:0] sync_s;
  logic [NUM_IN-1:0] prev_reg;

  assign pin_vec = {readout, ssr, swap, photons};

  // One equal-depth chain per input keeps photon and swap coherent.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clock) begin
        if (reset) chain_reg <= '0;
        else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_vec[gi]};
      end
      assign sync_s[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic photon_rise, swap_s, ssr_s, ssr_rise, ssr_fall, readout_rise;

  assign photon_rise  = sync_s[0] & ~prev_reg[0];
  assign swap_s       = sync_s[1];
  assign ssr_s        = sync_s[2];
  assign ssr_rise     = sync_s[2] & ~prev_reg[2];
  assign ssr_fall     = ~sync_s[2] & prev_reg[2];
  assign readout_rise = sync_s[3] & ~prev_reg[3];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] left_reg, left_next;
  logic [CNT_W-1:0] right_reg, right_next;
  logic [REP_W-1:0] rep_reg, rep_next;
  logic             ovf_reg, ovf_next;
  logic             flip_reg, flip_next;
  logic             dv_reg, busy_reg;

  logic [CNT_W:0] sum_lr;
  logic [CNT_W:0] left_plus_thr;

  // Extra bit keeps both sums exact at saturated counts.
  assign sum_lr        = {1'b0, left_reg} + {1'b0, right_reg};
  assign left_plus_thr = {1'b0, left_reg} + {1'b0, threshold};
  assign flip_next     = ({1'b0, right_reg} >= left_plus_thr) && (sum_lr >= {1'b0, min_total});

  always_comb begin
    state_next = state_reg;
    left_next  = left_reg;
    right_next = right_reg;
    rep_next   = rep_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (readout_rise)  state_next = DECIDE;
        else if (ssr_rise) state_next = ACCUM;
      end
      ACCUM: begin
        if (photon_rise && ssr_s) begin
          if (swap_s) begin
            if (right_reg == CNT_MAX) ovf_next = 1'b1;
            else                      right_next = right_reg + 1'b1;
          end else begin
            if (left_reg == CNT_MAX) ovf_next = 1'b1;
            else                     left_next = left_reg + 1'b1;
          end
        end
        if (ssr_fall && rep_reg != REP_MAX) rep_next = rep_reg + 1'b1;
        if (readout_rise ||
            (ssr_fall && rep_target != '0 && rep_next != rep_reg && rep_next == rep_target))
          state_next = DECIDE;
      end
      DECIDE: state_next = CLEAR;
      CLEAR: begin
        left_next  = '0;
        right_next = '0;
        rep_next   = '0;
        ovf_next   = 1'b0;
        state_next = ssr_s ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_reg  <= '0;
      state_reg <= IDLE;
      left_reg  <= '0;
      right_reg <= '0;
      rep_reg   <= '0;
      ovf_reg   <= 1'b0;
      flip_reg  <= 1'b0;
      dv_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      prev_reg  <= sync_s;
      state_reg <= state_next;
      left_reg  <= left_next;
      right_reg <= right_next;
      rep_reg   <= rep_next;
      ovf_reg   <= ovf_next;
      dv_reg    <= (state_reg == DECIDE);
      busy_reg  <= (state_next == ACCUM) || (state_next == DECIDE);
      if (state_reg == DECIDE) flip_reg <= flip_next;
    end
  end

  assign flip           = flip_reg;
  assign decision_valid = dv_reg;
  assign count_left     = left_reg;
  assign count_right    = right_reg;
  assign rep_count      = rep_reg;
  assign busy           = busy_reg;
  assign overflow       = ovf_reg;

endmodule

// File: tb/tb_ssr_photon_decider.sv
// Directed bench for ssr_photon_decider: a 16-bit instance for the main function
// and a 4-bit instance sharing the same pins for saturation behaviour.
module tb_ssr_photon_decider;

  logic        clock = 1'b0;
  logic        reset, photons, swap, ssr, readout;
  logic [15:0] threshold, min_total, rep_target;
  logic [3:0]  thr4, min4;

  logic        flip, decision_valid, busy, overflow;
  logic [15:0] count_left, count_right, rep_count;
  logic        flip4, dv4, busy4, ovf4;
  logic [3:0]  cl4, cr4;
  logic [15:0] rc4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ssr_photon_decider #(.CNT_W(16), .REP_W(16), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .photons(photons), .swap(swap), .ssr(ssr),
    .readout(readout), .threshold(threshold), .min_total(min_total),
    .rep_target(rep_target), .flip(flip), .decision_valid(decision_valid),
    .count_left(count_left), .count_right(count_right), .rep_count(rep_count),
    .busy(busy), .overflow(overflow)
  );

  ssr_photon_decider #(.CNT_W(4), .REP_W(16), .SYNC_STAGES(2)) dut4 (
    .clock(clock), .reset(reset), .photons(photons), .swap(swap), .ssr(ssr),
    .readout(readout), .threshold(thr4), .min_total(min4),
    .rep_target(rep_target), .flip(flip4), .decision_valid(dv4),
    .count_left(cl4), .count_right(cr4), .rep_count(rc4),
    .busy(busy4), .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic photon(input logic side);
    swap = side; photons = 1'b1; cyc(2);
    photons = 1'b0; cyc(2);
  endtask

  task automatic window(input int nl, input int nr);
    ssr = 1'b1; cyc(5);
    repeat (nl) photon(1'b0);
    repeat (nr) photon(1'b1);
    ssr = 1'b0; cyc(5);
  endtask

  task automatic wait_dv(input string tag);
    int n;
    n = 0;
    while (decision_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(decision_valid), 32'd1);
  endtask

  task automatic readout_pulse(input string tag);
    readout = 1'b1; cyc(2);
    readout = 1'b0;
    wait_dv(tag);
  endtask

  initial begin
    reset = 1'b1; photons = 1'b0; swap = 1'b0; ssr = 1'b0; readout = 1'b0;
    threshold = 16'd0; min_total = 16'd0; rep_target = 16'd0;
    thr4 = 4'd0; min4 = 4'd0;
    @(negedge clock); cyc(2);
    reset = 1'b0;
    cyc(10);

    // Reset and idle
    check("rst_flip", 32'(flip), 32'd0);
    check("rst_dv", 32'(decision_valid), 32'd0);
    check("rst_left", 32'(count_left), 32'd0);
    check("rst_right", 32'(count_right), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 3 left, 12 right, threshold 5, min 10 with exact latency
    threshold = 16'd5; min_total = 16'd10;
    window(3, 12);
    check("t2_left", 32'(count_left), 32'd3);
    check("t2_right", 32'(count_right), 32'd12);
    check("t2_rep", 32'(rep_count), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    readout = 1'b1;
    cyc(1); check("t2_dv_e1", 32'(decision_valid), 32'd0);
    cyc(1); check("t2_dv_e2", 32'(decision_valid), 32'd0);
    cyc(1); check("t2_dv_e3", 32'(decision_valid), 32'd0);
    cyc(1); check("t2_dv_e4", 32'(decision_valid), 32'd1);
    check("t2_flip", 32'(flip), 32'd1);
    readout = 1'b0;
    cyc(1); check("t2_dv_e5", 32'(decision_valid), 32'd0);
    cyc(1);
    check("t2_clr_left", 32'(count_left), 32'd0);
    check("t2_clr_right", 32'(count_right), 32'd0);
    check("t2_clr_rep", 32'(rep_count), 32'd0);
    check("t2_clr_busy", 32'(busy), 32'd0);
    check("t2_flip_held", 32'(flip), 32'd1);

    // 4 left, 5 right: margin met but total 9 below min 10
    threshold = 16'd0; min_total = 16'd10;
    window(4, 5);
    readout_pulse("t3_dv");
    check("t3_flip", 32'(flip), 32'd0);
    cyc(4);

    // Automatic decision after three repetitions of 2 right photons
    rep_target = 16'd3; threshold = 16'd6; min_total = 16'd0;
    window(0, 2);
    window(0, 2);
    check("t4_rep2", 32'(rep_count), 32'd2);
    check("t4_busy2", 32'(busy), 32'd1);
    ssr = 1'b1; cyc(5);
    photon(1'b1); photon(1'b1);
    ssr = 1'b0;
    wait_dv("t4_dv");
    check("t4_rep", 32'(rep_count), 32'd3);
    check("t4_right", 32'(count_right), 32'd6);
    check("t4_flip", 32'(flip), 32'd1);
    rep_target = 16'd0;
    cyc(4);

    // threshold 10 rejects 12 vs 3
    threshold = 16'd10; min_total = 16'd10;
    window(3, 12);
    readout_pulse("t5_dv");
    check("t5_flip", 32'(flip), 32'd0);
    cyc(4);

    // Readout from IDLE on zero counts with zero limits
    threshold = 16'd0; min_total = 16'd0;
    readout_pulse("t5b_dv");
    check("t5b_flip", 32'(flip), 32'd1);
    check("t5b_left", 32'(count_left), 32'd0);
    cyc(4);

    // 4-bit saturation
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(2);
    check("t6_rst_flip", 32'(flip), 32'd0);
    thr4 = 4'd15; min4 = 4'd0;
    ssr = 1'b1; cyc(5);
    repeat (15) photon(1'b1);
    check("t6_cr4_15", 32'(cr4), 32'd15);
    check("t6_ovf4_pre", 32'(ovf4), 32'd0);
    photon(1'b1); photon(1'b1);
    ssr = 1'b0; cyc(5);
    check("t6_cr4_sat", 32'(cr4), 32'd15);
    check("t6_ovf4", 32'(ovf4), 32'd1);
    check("t6_right16", 32'(count_right), 32'd17);
    check("t6_ovf16", 32'(overflow), 32'd0);
    readout_pulse("t6_dv");
    check("t6_dv4", 32'(dv4), 32'd1);
    check("t6_flip4", 32'(flip4), 32'd1);
    check("t6_flip16", 32'(flip), 32'd1);
    cyc(2);
    check("t6_ovf4_clr", 32'(ovf4), 32'd0);
    check("t6_cr4_clr", 32'(cr4), 32'd0);
    cyc(2);

    // Reset during accumulation
    ssr = 1'b1; cyc(5);
    repeat (7) photon(1'b1);
    check("t7_right", 32'(count_right), 32'd7);
    check("t7_flip_pre", 32'(flip), 32'd1);
    ssr = 1'b0; reset = 1'b1;
    cyc(1);
    check("t7_right0", 32'(count_right), 32'd0);
    check("t7_busy0", 32'(busy), 32'd0);
    check("t7_flip0", 32'(flip), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t7_no_dv", 32'(decision_valid), 32'd0);
      cyc(1);
    end

    // Photon coinciding with readout is counted before evaluation
    threshold = 16'd3; min_total = 16'd0;
    ssr = 1'b1; cyc(5);
    photon(1'b1); photon(1'b1);
    swap = 1'b1; photons = 1'b1; readout = 1'b1;
    cyc(2);
    photons = 1'b0; readout = 1'b0;
    wait_dv("t8_dv");
    check("t8_right", 32'(count_right), 32'd3);
    check("t8_flip", 32'(flip), 32'd1);
    ssr = 1'b0;
    cyc(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
